// File: rtl/mac_job_sequencer.sv
// rtl/mac_job_sequencer.sv - multi-tile dot-product job sequencer in front of a 3-stage mac_unit
module mac_job_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 4,
  parameter int MAX_TILES  = 16,
  localparam int TW = $clog2(MAX_TILES + 1),
  localparam int MW = 2 * DATA_WIDTH + $clog2(LENGTH),
  localparam int OW = MW + $clog2(MAX_TILES)
) (
  input  logic                         i_clk,
  input  logic                         i_nrst_async,
  input  logic                         i_cfg_valid,
  output logic                         o_cfg_ready,
  input  logic [TW-1:0]                i_cfg_tiles,
  input  logic                         i_tile_valid,
  output logic                         o_tile_ready,
  input  logic signed [DATA_WIDTH-1:0] i_tile_a [LENGTH],
  input  logic signed [DATA_WIDTH-1:0] i_tile_b [LENGTH],
  output logic                         o_mac_start,
  output logic signed [DATA_WIDTH-1:0] o_mac_vecA [LENGTH],
  output logic signed [DATA_WIDTH-1:0] o_mac_vecB [LENGTH],
  input  logic signed [MW-1:0]         i_mac_result,
  input  logic                         i_mac_valid,
  output logic signed [OW-1:0]         o_result,
  output logic                         o_result_valid,
  input  logic                         i_result_ready,
  output logic                         o_busy,
  output logic                         o_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [TW-1:0] MAX_T = TW'(MAX_TILES);
  localparam logic [TW-1:0] ONE_T = TW'(1);

  logic [1:0]           state;
  logic [TW-1:0]        tiles;
  logic [TW-1:0]        issued;
  logic [TW-1:0]        returned;
  logic signed [OW-1:0] acc;
  logic                 err;

  logic cfg_fire;
  logic tile_fire;
  logic mac_take;
  logic mac_stray;
  logic last_return;
  logic last_issue;

  assign cfg_fire    = i_cfg_valid && (state == S_IDLE);
  assign tile_fire   = i_tile_valid && (state == S_ISSUE);
  // issued never falls behind returned, so inequality means work is outstanding
  assign mac_take    = i_mac_valid && (issued != returned);
  assign mac_stray   = i_mac_valid && (issued == returned);
  assign last_return = mac_take && ((returned + ONE_T) == tiles);
  assign last_issue  = (issued + ONE_T) == tiles;

  assign o_cfg_ready    = (state == S_IDLE);
  assign o_tile_ready   = (state == S_ISSUE);
  assign o_result_valid = (state == S_DONE);
  assign o_busy         = (state != S_IDLE);
  assign o_result       = acc;
  assign o_err          = err;

  // Job FSM, return accounting and accumulation; cfg accept overrides the generic return path
  always_ff @(posedge i_clk or negedge i_nrst_async) begin
    if (!i_nrst_async) begin
      state    <= S_IDLE;
      tiles    <= '0;
      issued   <= '0;
      returned <= '0;
      acc      <= '0;
      err      <= 1'b0;
    end else begin
      if (mac_take) begin
        acc      <= acc + OW'(i_mac_result);
        returned <= returned + ONE_T;
      end
      if (mac_stray) err <= 1'b1;
      if (last_return) state <= S_DONE;

      case (state)
        S_IDLE: begin
          if (cfg_fire) begin
            tiles    <= i_cfg_tiles;
            issued   <= '0;
            returned <= '0;
            acc      <= '0;
            err      <= (i_cfg_tiles > MAX_T) || mac_stray;
            if (i_cfg_tiles == '0 || i_cfg_tiles > MAX_T) state <= S_DONE;
            else                                          state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (tile_fire) begin
            issued <= issued + ONE_T;
            if (last_issue) state <= S_DRAIN;
          end
        end
        S_DRAIN: ;
        S_DONE: begin
          if (i_result_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand registers hold the last issued tile; start pulses the cycle after each tile handshake
  always_ff @(posedge i_clk or negedge i_nrst_async) begin
    if (!i_nrst_async) begin
      o_mac_start <= 1'b0;
      for (int i = 0; i < LENGTH; i++) begin
        o_mac_vecA[i] <= '0;
        o_mac_vecB[i] <= '0;
      end
    end else begin
      o_mac_start <= tile_fire;
      if (tile_fire) begin
        for (int i = 0; i < LENGTH; i++) begin
          o_mac_vecA[i] <= i_tile_a[i];
          o_mac_vecB[i] <= i_tile_b[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_job_sequencer.sv
// tb/tb_mac_job_sequencer.sv - self-checking bench for mac_job_sequencer with a 3-stage MAC stand-in
module tb_mac_job_sequencer;
  localparam int DW = 8;
  localparam int L  = 4;
  localparam int MT = 16;
  localparam int TW = 5;
  localparam int MW = 18;
  localparam int OW = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [TW-1:0]        cfg_tiles;
  logic                 tile_valid;
  logic                 tile_ready;
  logic signed [DW-1:0] tile_a [L];
  logic signed [DW-1:0] tile_b [L];
  logic                 mac_start;
  logic signed [DW-1:0] mac_vec_a [L];
  logic signed [DW-1:0] mac_vec_b [L];
  logic signed [MW-1:0] mac_result;
  logic                 mac_valid;
  logic signed [OW-1:0] result;
  logic                 result_valid;
  logic                 result_ready;
  logic                 busy;
  logic                 err;

  mac_job_sequencer #(.DATA_WIDTH(DW), .LENGTH(L), .MAX_TILES(MT)) dut (
    .i_clk(clk), .i_nrst_async(rst_n),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready), .i_cfg_tiles(cfg_tiles),
    .i_tile_valid(tile_valid), .o_tile_ready(tile_ready),
    .i_tile_a(tile_a), .i_tile_b(tile_b),
    .o_mac_start(mac_start), .o_mac_vecA(mac_vec_a), .o_mac_vecB(mac_vec_b),
    .i_mac_result(mac_result), .i_mac_valid(mac_valid),
    .o_result(result), .o_result_valid(result_valid), .i_result_ready(result_ready),
    .o_busy(busy), .o_err(err)
  );

  // MAC unit stand-in: dot product, valid three edges after start is sampled
  logic                 v1, v2, v3;
  logic signed [MW-1:0] r1, r2, r3;
  logic                 force_v;
  logic signed [MW-1:0] force_r;

  function automatic int dotp(input logic signed [DW-1:0] a [L], input logic signed [DW-1:0] b [L]);
    int s = 0;
    for (int i = 0; i < L; i++) s += int'(a[i]) * int'(b[i]);
    return s;
  endfunction

  // Pipeline of the MAC stand-in, flushed together with the sequencer reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      r1 <= '0;   r2 <= '0;   r3 <= '0;
    end else begin
      v1 <= mac_start; r1 <= MW'(dotp(mac_vec_a, mac_vec_b));
      v2 <= v1;        r2 <= r1;
      v3 <= v2;        r3 <= r2;
    end
  end

  assign mac_valid  = v3 | force_v;
  assign mac_result = force_v ? force_r : r3;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input int n);
    int c = 0;
    cfg_valid = 1'b1;
    cfg_tiles = TW'(n);
    while (!cfg_ready && c < 50) begin step(); c++; end
    chk("cfg_ready_wait", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
  endtask

  // Streams n tiles; rnd picks random operands and random gaps up to gap, else fixed operands/gaps
  task automatic do_tiles(input int n, input int gap, input bit rnd,
                          input logic signed [DW-1:0] fa [L], input logic signed [DW-1:0] fb [L],
                          output int sum);
    int c;
    int g;
    sum = 0;
    for (int t = 0; t < n; t++) begin
      g = rnd ? int'($urandom_range(0, gap)) : ((t == 0) ? 0 : gap);
      if (g > 0) begin
        tile_valid = 1'b0;
        repeat (g) step();
      end
      for (int i = 0; i < L; i++) begin
        tile_a[i] = rnd ? DW'($urandom) : fa[i];
        tile_b[i] = rnd ? DW'($urandom) : fb[i];
      end
      sum += dotp(tile_a, tile_b);
      tile_valid = 1'b1;
      c = 0;
      while (!tile_ready && c < 50) begin step(); c++; end
      chk("tile_ready_wait", tile_ready, 1);
      step();
      chk("mac_start_after_tile", mac_start, 1);
      chk("mac_vec_a0", mac_vec_a[0], tile_a[0]);
    end
    tile_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 1;
    while (!result_valid && cycles < 80) begin step(); cycles++; end
    chk("result_valid_wait", result_valid, 1);
  endtask

  task automatic accept();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  logic signed [DW-1:0] fa [L];
  logic signed [DW-1:0] fb [L];
  int sum;
  int cyc;
  int n;

  initial begin
    rst_n = 1'b1; cfg_valid = 1'b0; cfg_tiles = '0; tile_valid = 1'b0; result_ready = 1'b0;
    force_v = 1'b0; force_r = '0;
    for (int i = 0; i < L; i++) begin tile_a[i] = '0; tile_b[i] = '0; end

    // 1: asynchronous reset seen without a clock edge
    step(); step();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_mac_start", mac_start, 0);
    chk("rst_tile_ready", tile_ready, 0);
    step();
    rst_n = 1'b1;
    step();

    // 2: single tile, result 70 five cycles after the tile handshake
    fa = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    fb = '{8'sd5, 8'sd6, 8'sd7, 8'sd8};
    send_cfg(1);
    chk("single_busy", busy, 1);
    do_tiles(1, 0, 1'b0, fa, fb, sum);
    wait_valid(cyc);
    chk("single_latency", cyc, 5);
    chk("single_result", result, 70);
    chk("single_err", err, 0);
    accept();

    // 3: four back-to-back full-scale negative tiles
    for (int i = 0; i < L; i++) begin fa[i] = -8'sd128; fb[i] = -8'sd128; end
    send_cfg(4);
    do_tiles(4, 0, 1'b0, fa, fb, sum);
    step();
    chk("b2b_start_drops", mac_start, 0);
    chk("drain_tile_ready", tile_ready, 0);
    wait_valid(cyc);
    chk("b2b_result", result, 262144);
    accept();

    // 4: gapped tiles, result held while downstream stalls
    fa = '{8'sd127, -8'sd128, 8'sd1, -8'sd1};
    fb = '{-8'sd1, 8'sd1, 8'sd1, 8'sd1};
    send_cfg(3);
    do_tiles(3, 2, 1'b0, fa, fb, sum);
    wait_valid(cyc);
    chk("gap_result", result, -765);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("stall_result", result, -765);
      chk("stall_valid", result_valid, 1);
    end
    accept();
    chk("after_accept_cfg_ready", cfg_ready, 1);
    chk("after_accept_valid", result_valid, 0);

    // 5: empty and oversized jobs
    send_cfg(0);
    chk("zero_valid", result_valid, 1);
    chk("zero_result", result, 0);
    chk("zero_err", err, 0);
    accept();
    send_cfg(MT + 1);
    chk("over_valid", result_valid, 1);
    chk("over_result", result, 0);
    chk("over_err", err, 1);
    accept();

    // 6: reset while draining, then a stray MAC return
    send_cfg(2);
    chk("cfg_clears_err", err, 0);
    do_tiles(2, 0, 1'b1, fa, fb, sum);
    chk("drain_busy", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("midjob_rst_busy", busy, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_err", err, 0);
    force_v = 1'b1; force_r = MW'(99);
    step();
    force_v = 1'b0;
    chk("stray_err", err, 1);
    chk("stray_acc", result, 0);
    chk("stray_idle", cfg_ready, 1);
    step();

    // Randomized jobs against the summed dot products
    for (int j = 0; j < 8; j++) begin
      n = int'($urandom_range(1, MT));
      send_cfg(n);
      do_tiles(n, 2, 1'b1, fa, fb, sum);
      wait_valid(cyc);
      chk("rand_result", result, sum);
      chk("rand_err", err, 0);
      repeat ($urandom_range(0, 3)) step();
      chk("rand_result_held", result, sum);
      accept();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
